// File: rtl/isp_cfg_pkg.sv
// Shared types and default sizes for the ISP configuration scheduler.
package isp_cfg_pkg;

  localparam int unsigned DEF_NUM_REG = 4;
  localparam int unsigned DEF_ADDR_W  = 2;
  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_FCNT_W  = 16;

  // Register map of the config bank
  typedef enum logic [1:0] {
    REG_DPC_THRESH = 2'd0,
    REG_BAYER      = 2'd1,  // bits[1:0] select the CFA pattern
    REG_BYPASS     = 2'd2,  // bit0: DPC bypass
    REG_TEST       = 2'd3   // bit0: colour-bar enable
  } cfg_reg_e;

  // Encoding of REG_BAYER[1:0]
  typedef enum logic [1:0] {
    BAYER_RGGB = 2'd0,
    BAYER_GRBG = 2'd1,
    BAYER_GBRG = 2'd2,
    BAYER_BGGR = 2'd3
  } bayer_e;

  // Scheduler states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STAGED = 2'd1,
    COMMIT = 2'd2
  } sched_state_e;

endpackage

// File: rtl/isp_cfg_scheduler_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the favoured
// requester when both ask in the same cycle.
module rr_arb2 (
  input  logic       pixel_clk,
  input  logic       sys_rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic ptr;

  // Combinational grant: a lone requester wins, a tie goes to the pointer
  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  // After an accepted transfer, favour the other requester
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= ~grant[1];
    end
  end

endmodule

// File: rtl/isp_cfg_scheduler.sv
// Frame-synchronous configuration scheduler: writes land in a staging
// bank that is copied to the active bank once per frame start, so ISP
// parameters never change mid-frame.
module isp_cfg_scheduler
  import isp_cfg_pkg::*;
#(
  parameter int unsigned NUM_REG = DEF_NUM_REG,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned FCNT_W  = DEF_FCNT_W
) (
  input  logic                      pixel_clk,
  input  logic                      sys_rst,
  input  logic                      req0_valid,
  input  logic [ADDR_W-1:0]         req0_addr,
  input  logic [DATA_W-1:0]         req0_data,
  output logic                      req0_ready,
  input  logic                      req1_valid,
  input  logic [ADDR_W-1:0]         req1_addr,
  input  logic [DATA_W-1:0]         req1_data,
  output logic                      req1_ready,
  input  logic                      video_vs,
  input  logic                      cfg_freeze,
  output logic [NUM_REG*DATA_W-1:0] cfg_active,
  output logic                      cfg_update,
  output logic                      cfg_dirty,
  output logic [FCNT_W-1:0]         frame_cnt
);

  sched_state_e       state, state_nxt;
  logic               vs_d;
  logic               vs_rise;
  logic [FCNT_W-1:0]  fcnt_q;
  logic [1:0]         grant;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic [DATA_W-1:0]  staging [NUM_REG];
  logic [DATA_W-1:0]  active  [NUM_REG];

  assign vs_rise   = video_vs & ~vs_d;
  assign frame_cnt = fcnt_q;

  rr_arb2 u_arb (
    .pixel_clk (pixel_clk),
    .sys_rst   (sys_rst),
    .req       ({req1_valid, req0_valid}),
    .accept    (wr_en),
    .grant     (grant)
  );

  // Handshake and write-port mux; both readies are held low during COMMIT
  always_comb begin
    req0_ready = grant[0] & (state != COMMIT);
    req1_ready = grant[1] & (state != COMMIT);
    wr_en      = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    wr_addr    = grant[1] ? req1_addr : req0_addr;
    wr_data    = grant[1] ? req1_data : req0_data;
  end

  // Frame-start edge detect and free-running frame counter
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vs_d   <= 1'b0;
      fcnt_q <= '0;
    end else begin
      vs_d <= video_vs;
      if (vs_rise) begin
        fcnt_q <= fcnt_q + FCNT_W'(1);
      end
    end
  end

  // State register
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr_en) state_nxt = STAGED;
      STAGED:  if (vs_rise && !cfg_freeze) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Staging writes, commit copy, dirty flag and update pulse.
  // The copy is taken in COMMIT rather than on vs_rise so that a write
  // accepted alongside the frame-start edge is part of the same commit.
  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int unsigned i = 0; i < NUM_REG; i++) begin
        staging[i] <= '0;
        active[i]  <= '0;
      end
      cfg_dirty  <= 1'b0;
      cfg_update <= 1'b0;
    end else begin
      cfg_update <= 1'b0;
      if (wr_en) begin
        staging[wr_addr] <= wr_data;
        cfg_dirty        <= 1'b1;
      end
      if (state == COMMIT) begin
        for (int unsigned i = 0; i < NUM_REG; i++) begin
          active[i] <= staging[i];
        end
        cfg_dirty  <= 1'b0;
        cfg_update <= 1'b1;
      end
    end
  end

  // Flatten the active bank onto the output bus
  always_comb begin
    cfg_active = '0;
    for (int unsigned i = 0; i < NUM_REG; i++) begin
      cfg_active[i*DATA_W +: DATA_W] = active[i];
    end
  end

endmodule

// File: tb/tb_isp_cfg_scheduler.sv
// Directed self-checking bench for isp_cfg_scheduler.
module tb_isp_cfg_scheduler;

  logic        pixel_clk;
  logic        sys_rst;
  logic        req0_valid, req1_valid;
  logic [1:0]  req0_addr, req1_addr;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        video_vs;
  logic        cfg_freeze;
  logic [63:0] cfg_active;
  logic        cfg_update;
  logic        cfg_dirty;
  logic [15:0] frame_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] exp_fc;

  isp_cfg_scheduler #(
    .NUM_REG (4),
    .ADDR_W  (2),
    .DATA_W  (16),
    .FCNT_W  (16)
  ) dut (
    .pixel_clk  (pixel_clk),
    .sys_rst    (sys_rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .video_vs   (video_vs),
    .cfg_freeze (cfg_freeze),
    .cfg_active (cfg_active),
    .cfg_update (cfg_update),
    .cfg_dirty  (cfg_dirty),
    .frame_cnt  (frame_cnt)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and land 1ns after the rising edge
  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sys_rst    = 1'b1;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    video_vs   = 1'b0;
    cfg_freeze = 1'b0;
    exp_fc     = '0;

    // Reset values
    #12;
    chk("rst_active", cfg_active, 64'h0);
    chk("rst_update", {63'h0, cfg_update}, 64'h0);
    #1 sys_rst = 1'b0;
    repeat (10) step();
    chk("idle_active", cfg_active, 64'h0);
    chk("idle_update", {63'h0, cfg_update}, 64'h0);
    chk("idle_dirty", {63'h0, cfg_dirty}, 64'h0);
    chk("idle_fcnt", {48'h0, frame_cnt}, 64'h0);

    // Round-robin with both requesters on addr0; pointer starts at 0
    req0_valid = 1'b1; req0_addr = 2'd0; req0_data = 16'hAAAA;
    req1_valid = 1'b1; req1_addr = 2'd0; req1_data = 16'h5555;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("arb_r0", {63'h0, req0_ready}, {63'h0, (k % 2) == 0});
      chk("arb_r1", {63'h0, req1_ready}, {63'h0, (k % 2) == 1});
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1 chk("arb_dirty", {63'h0, cfg_dirty}, 64'h1);

    // Bayer register write, then frame start
    req0_valid = 1'b1; req0_addr = 2'd1; req0_data = 16'h0002;
    #1 chk("wr1_ready", {63'h0, req0_ready}, 64'h1);
    step();
    req0_valid = 1'b0;
    video_vs = 1'b1;
    step(); exp_fc++;
    // COMMIT cycle: nobody may write
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("commit_r0", {63'h0, req0_ready}, 64'h0);
    chk("commit_r1", {63'h0, req1_ready}, 64'h0);
    chk("commit_active_old", cfg_active, 64'h0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("c1_active", cfg_active, 64'h0000_0000_0002_5555);
    chk("c1_update", {63'h0, cfg_update}, 64'h1);
    chk("c1_dirty", {63'h0, cfg_dirty}, 64'h0);
    chk("c1_fcnt", {48'h0, frame_cnt}, {48'h0, exp_fc});
    step();
    chk("c1_update_low", {63'h0, cfg_update}, 64'h0);

    // video_vs held high: stage a write, no second edge means no commit
    req0_valid = 1'b1; req0_addr = 2'd3; req0_data = 16'h0001;
    step();
    req0_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("held_update", {63'h0, cfg_update}, 64'h0);
    end
    chk("held_dirty", {63'h0, cfg_dirty}, 64'h1);
    chk("held_fcnt", {48'h0, frame_cnt}, {48'h0, exp_fc});
    video_vs = 1'b0;
    step();

    // Write in the same cycle as vs_rise is part of that commit
    req0_valid = 1'b1; req0_addr = 2'd0; req0_data = 16'h0010;
    video_vs = 1'b1;
    #1 chk("same_ready", {63'h0, req0_ready}, 64'h1);
    step(); exp_fc++;
    req0_addr = 2'd1; req0_data = 16'h0003;
    #1 chk("same_commit_ready", {63'h0, req0_ready}, 64'h0);
    step();
    chk("same_active", cfg_active, 64'h0001_0000_0002_0010);
    chk("same_update", {63'h0, cfg_update}, 64'h1);
    chk("held_wr_ready", {63'h0, req0_ready}, 64'h1);
    step();
    req0_valid = 1'b0; video_vs = 1'b0;
    chk("held_wr_dirty", {63'h0, cfg_dirty}, 64'h1);
    chk("held_wr_update", {63'h0, cfg_update}, 64'h0);

    // Freeze across three frame starts
    req1_valid = 1'b1; req1_addr = 2'd2; req1_data = 16'h0001;
    #1 chk("frz_wr_ready", {63'h0, req1_ready}, 64'h1);
    step();
    req1_valid = 1'b0;
    cfg_freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      video_vs = 1'b1;
      step(); exp_fc++;
      chk("frz_update_a", {63'h0, cfg_update}, 64'h0);
      video_vs = 1'b0;
      step();
      chk("frz_update_b", {63'h0, cfg_update}, 64'h0);
    end
    chk("frz_dirty", {63'h0, cfg_dirty}, 64'h1);
    chk("frz_fcnt", {48'h0, frame_cnt}, {48'h0, exp_fc});
    chk("frz_active", cfg_active, 64'h0001_0000_0002_0010);
    cfg_freeze = 1'b0;
    video_vs = 1'b1;
    step(); exp_fc++;
    video_vs = 1'b0;
    step();
    chk("unfrz_active", cfg_active, 64'h0001_0001_0003_0010);
    chk("unfrz_update", {63'h0, cfg_update}, 64'h1);
    chk("unfrz_dirty", {63'h0, cfg_dirty}, 64'h0);

    // Reset asserted during COMMIT
    req0_valid = 1'b1; req0_addr = 2'd0; req0_data = 16'h1234;
    step();
    req0_valid = 1'b0;
    video_vs = 1'b1;
    step(); exp_fc++;
    chk("prerst_fcnt", {48'h0, frame_cnt}, {48'h0, exp_fc});
    sys_rst = 1'b1;
    #1;
    exp_fc = '0;
    chk("arst_active", cfg_active, 64'h0);
    chk("arst_update", {63'h0, cfg_update}, 64'h0);
    chk("arst_dirty", {63'h0, cfg_dirty}, 64'h0);
    chk("arst_fcnt", {48'h0, frame_cnt}, 64'h0);
    #1 sys_rst = 1'b0;
    video_vs = 1'b0;
    step();
    step();
    chk("postrst_active", cfg_active, 64'h0);
    chk("postrst_update", {63'h0, cfg_update}, 64'h0);

    // Frame counter wrap
    force dut.fcnt_q = 16'hFFFF;
    #1 release dut.fcnt_q;
    #1 chk("wrap_pre", {48'h0, frame_cnt}, 64'hFFFF);
    video_vs = 1'b1;
    step();
    chk("wrap_post", {48'h0, frame_cnt}, 64'h0);
    video_vs = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
